// File: rtl/cpu_accel_hub_if.sv
// ----------------------------------------------------------------------------
// cpu_accel_hub_if
//   CPU-side accelerator bus between the plotter CPU and cpu_accel_hub.
//   The CPU (master) picks a slot with accel_id and issues read/write
//   transfers. The hub (slave) answers with can_read/can_write status and
//   read data for the selected slot.
//
//   Signals
//     accel_id            master -> slave   ID_WIDTH    selected slot
//     accel_read_enable   master -> slave   1           read transfer this cycle
//     accel_write_enable  master -> slave   1           write transfer this cycle
//     accel_write_data    master -> slave   DATA_WIDTH  write data
//     accel_can_read      slave  -> master  1           selected slot has data
//     accel_can_write     slave  -> master  1           selected slot accepts data
//     accel_read_data     slave  -> master  DATA_WIDTH  selected slot read data
// ----------------------------------------------------------------------------
interface cpu_accel_hub_if #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 16
);
    logic [ID_WIDTH-1:0]   accel_id;
    logic                  accel_read_enable;
    logic                  accel_write_enable;
    logic [DATA_WIDTH-1:0] accel_write_data;
    logic                  accel_can_read;
    logic                  accel_can_write;
    logic [DATA_WIDTH-1:0] accel_read_data;

    modport master (
        output accel_id,
        output accel_read_enable,
        output accel_write_enable,
        output accel_write_data,
        input  accel_can_read,
        input  accel_can_write,
        input  accel_read_data
    );

    modport slave (
        input  accel_id,
        input  accel_read_enable,
        input  accel_write_enable,
        input  accel_write_data,
        output accel_can_read,
        output accel_can_write,
        output accel_read_data
    );
endinterface

// File: rtl/cpu_accel_hub.sv
// ----------------------------------------------------------------------------
// cpu_accel_hub
//   Accelerator interconnect and run controller for the plotter CPU.
//   Decodes the CPU accelerator bus onto NUM_ACCELS slots. Slot 0 is the
//   internal control slot: reads return the run argument, a write delivers
//   the result code and ends the run. Slots 1..NUM_ACCELS-1 are external.
//   The controller holds the CPU in reset until a start request, releases it
//   after RST_CYCLES and reports the result when the CPU finishes.
//
//   Optional feature: define ACCEL_WATCHDOG_EN to abort a run after
//   WATCHDOG_CYCLES consecutive cycles without bus activity (result all
//   ones, timeout set). Without the macro, timeout stays 0 and a stalled
//   CPU remains in RUN until i_rst.
//
//   Ports
//     i_clk                in   1                      clock
//     i_rst                in   1                      synchronous active-high reset
//     i_start              in   1                      begin run (sampled in IDLE only)
//     i_arg                in   DATA_WIDTH             run argument, latched on start
//     o_ready              out  1                      controller idle
//     o_result             out  DATA_WIDTH             last result code
//     o_result_valid       out  1                      one-cycle pulse on result update
//     o_timeout            out  1                      sticky: last run hit the watchdog
//     o_cpu_rst            out  1                      CPU reset
//     cpu_bus              slave modport of cpu_accel_hub_if
//     i_slot_can_read      in   NUM_ACCELS             per-slot can_read (bit 0 unused)
//     i_slot_can_write     in   NUM_ACCELS             per-slot can_write (bit 0 unused)
//     i_slot_read_data     in   NUM_ACCELS*DATA_WIDTH  slot i at [i*DW +: DW]
//     o_slot_read_enable   out  NUM_ACCELS             one-hot read strobe
//     o_slot_write_enable  out  NUM_ACCELS             one-hot write strobe
//     o_slot_write_data    out  DATA_WIDTH             broadcast CPU write data
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   ST_IDLE  | CPU held in reset, waiting for i_start
//   ST_RESET | CPU held in reset for RST_CYCLES after start
//   ST_RUN   | CPU running, bus strobes forwarded to slots
// ----------------------------------------------------------------------------
module cpu_accel_hub #(
    parameter int NUM_ACCELS      = 4,
    parameter int ID_WIDTH        = 4,
    parameter int DATA_WIDTH      = 16,
    parameter int RST_CYCLES      = 4,
    parameter int WATCHDOG_CYCLES = 4096
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_start,
    input  logic [DATA_WIDTH-1:0]            i_arg,
    output logic                             o_ready,
    output logic [DATA_WIDTH-1:0]            o_result,
    output logic                             o_result_valid,
    output logic                             o_timeout,
    output logic                             o_cpu_rst,
    cpu_accel_hub_if.slave                   cpu_bus,
    input  logic [NUM_ACCELS-1:0]            i_slot_can_read,
    input  logic [NUM_ACCELS-1:0]            i_slot_can_write,
    input  logic [NUM_ACCELS*DATA_WIDTH-1:0] i_slot_read_data,
    output logic [NUM_ACCELS-1:0]            o_slot_read_enable,
    output logic [NUM_ACCELS-1:0]            o_slot_write_enable,
    output logic [DATA_WIDTH-1:0]            o_slot_write_data
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RESET = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    logic [1:0]            r_state;
    logic [RC_W-1:0]       r_rst_cnt;
    logic [DATA_WIDTH-1:0] r_arg;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_result_valid;
    logic                  r_timeout;

    logic                  w_run;
    logic [NUM_ACCELS-1:0] w_sel;
    logic                  w_can_read;
    logic                  w_can_write;
    logic [DATA_WIDTH-1:0] w_read_data;
    logic                  w_ctrl_write;
    logic                  w_wd_expire;
    logic                  w_unused;

    assign w_run = (r_state == ST_RUN);

    // One-hot slot select; ids at or above NUM_ACCELS leave it all zero,
    // which drops strobes for out-of-range transfers.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_ACCELS; i++) begin
            if (cpu_bus.accel_id == ID_WIDTH'(i)) begin
                w_sel[i] = 1'b1;
            end
        end
    end

    // Status/data mux. Defaults cover the out-of-range case: nothing to
    // read, writes always "accepted" so the CPU never blocks on a bad id.
    always_comb begin
        w_can_read  = 1'b0;
        w_can_write = 1'b1;
        w_read_data = '0;
        for (int i = 1; i < NUM_ACCELS; i++) begin
            if (w_sel[i]) begin
                w_can_read  = i_slot_can_read[i];
                w_can_write = i_slot_can_write[i];
                w_read_data = i_slot_read_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (w_sel[0]) begin
            w_can_read  = w_run;
            w_can_write = w_run;
            w_read_data = r_arg;
        end
    end

    assign cpu_bus.accel_can_read  = w_can_read;
    assign cpu_bus.accel_can_write = w_can_write;
    assign cpu_bus.accel_read_data = w_read_data;

    assign o_slot_read_enable  = w_sel & {NUM_ACCELS{cpu_bus.accel_read_enable  && w_run}};
    assign o_slot_write_enable = w_sel & {NUM_ACCELS{cpu_bus.accel_write_enable && w_run}};
    assign o_slot_write_data   = cpu_bus.accel_write_data;

    assign w_ctrl_write = w_run && cpu_bus.accel_write_enable && w_sel[0];

`ifdef ACCEL_WATCHDOG_EN
    localparam int WD_W = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;

    logic [WD_W-1:0] r_wd_cnt;
    logic            w_bus_active;

    assign w_bus_active = cpu_bus.accel_read_enable || cpu_bus.accel_write_enable;

    // Down-counter reloaded on any transfer; expiry fires on the
    // WATCHDOG_CYCLES-th consecutive idle RUN cycle.
    assign w_wd_expire = w_run && !w_bus_active && (r_wd_cnt == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wd_cnt <= WD_W'(WATCHDOG_CYCLES - 1);
        end else if (!w_run || w_bus_active) begin
            r_wd_cnt <= WD_W'(WATCHDOG_CYCLES - 1);
        end else if (r_wd_cnt != '0) begin
            r_wd_cnt <= r_wd_cnt - WD_W'(1);
        end
    end

    assign w_unused = ^{i_slot_can_read[0], i_slot_can_write[0],
                        i_slot_read_data[DATA_WIDTH-1:0]};
`else
    assign w_wd_expire = 1'b0;

    assign w_unused = ^{i_slot_can_read[0], i_slot_can_write[0],
                        i_slot_read_data[DATA_WIDTH-1:0],
                        (WATCHDOG_CYCLES > 0)};
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_rst_cnt      <= '0;
            r_arg          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_arg     <= i_arg;
                        r_timeout <= 1'b0;
                        r_rst_cnt <= RC_W'(RST_CYCLES - 1);
                        r_state   <= ST_RESET;
                    end
                end
                ST_RESET: begin
                    if (r_rst_cnt == '0) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_rst_cnt <= r_rst_cnt - RC_W'(1);
                    end
                end
                ST_RUN: begin
                    if (w_ctrl_write) begin
                        r_result       <= cpu_bus.accel_write_data;
                        r_result_valid <= 1'b1;
                        r_state        <= ST_IDLE;
                    end else if (w_wd_expire) begin
                        r_result       <= '1;
                        r_result_valid <= 1'b1;
                        r_timeout      <= 1'b1;
                        r_state        <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_ready        = (r_state == ST_IDLE);
    assign o_cpu_rst      = !w_run;
    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;
    assign o_timeout      = r_timeout;

endmodule

// File: tb/tb_cpu_accel_hub.sv
// ----------------------------------------------------------------------------
// tb_cpu_accel_hub
//   Self-checking bench for cpu_accel_hub: directed run sequences, a decode
//   vector table applied during RUN, and a randomized phase checked against
//   a timeline-based reference model. Build with ACCEL_WATCHDOG_EN defined
//   to exercise the watchdog abort path (WATCHDOG_CYCLES = 16 here).
// ----------------------------------------------------------------------------
module tb_cpu_accel_hub;

    localparam int NUM  = 4;
    localparam int IDW  = 4;
    localparam int DW   = 16;
    localparam int RSTC = 4;
    localparam int WDC  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [DW-1:0]     arg;
    logic              ready;
    logic [DW-1:0]     result;
    logic              result_valid;
    logic              timeout;
    logic              cpu_rst;
    logic [NUM-1:0]    scr;
    logic [NUM-1:0]    scw;
    logic [NUM*DW-1:0] srd;
    logic [NUM-1:0]    srs;
    logic [NUM-1:0]    sws;
    logic [DW-1:0]     swd;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cpu_accel_hub_if #(.ID_WIDTH(IDW), .DATA_WIDTH(DW)) cpu_bus ();

    cpu_accel_hub #(
        .NUM_ACCELS     (NUM),
        .ID_WIDTH       (IDW),
        .DATA_WIDTH     (DW),
        .RST_CYCLES     (RSTC),
        .WATCHDOG_CYCLES(WDC)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_start            (start),
        .i_arg              (arg),
        .o_ready            (ready),
        .o_result           (result),
        .o_result_valid     (result_valid),
        .o_timeout          (timeout),
        .o_cpu_rst          (cpu_rst),
        .cpu_bus            (cpu_bus),
        .i_slot_can_read    (scr),
        .i_slot_can_write   (scw),
        .i_slot_read_data   (srd),
        .o_slot_read_enable (srs),
        .o_slot_write_enable(sws),
        .o_slot_write_data  (swd)
    );

    typedef struct {
        logic [IDW-1:0] id;
        logic           re;
        logic           we;
        logic [DW-1:0]  wd;
        logic [NUM-1:0] scr;
        logic [NUM-1:0] scw;
        logic           cr;
        logic           cw;
        logic [DW-1:0]  rd;
        logic [NUM-1:0] rs;
        logic [NUM-1:0] ws;
    } vec_t;

    vec_t vt[8];

    // reference model state (timeline based)
    int            m_cyc;
    int            m_t0;
    bit            m_busy;
    logic [DW-1:0] m_arg;
    logic [DW-1:0] m_result;
    bit            m_rv;
    bit            m_timeout;
    int            m_idle;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic bus_idle();
        cpu_bus.accel_id           = '0;
        cpu_bus.accel_read_enable  = 1'b0;
        cpu_bus.accel_write_enable = 1'b0;
        cpu_bus.accel_write_data   = '0;
    endtask

    // Accepts a start in the current cycle and returns in the first RUN cycle.
    task automatic start_run(input logic [DW-1:0] a);
        next();
        start = 1'b1;
        arg   = a;
        settle();
        chk("start_ready", ready, 1);
        next();
        start = 1'b0;
        settle();
        chk("reset_ready_low", ready, 0);
        for (int k = 0; k < RSTC; k++) begin
            chk("reset_cpu_rst_high", cpu_rst, 1);
            next();
            settle();
        end
        chk("run_cpu_rst_low", cpu_rst, 0);
        chk("run_ready_low", ready, 0);
    endtask

    function automatic bit m_run();
        return m_busy && (m_cyc >= m_t0 + 1 + RSTC);
    endfunction

    task automatic model_check();
        bit            run;
        int            id;
        bit            inr;
        logic          e_cr;
        logic          e_cw;
        logic [DW-1:0] e_rd;
        logic [NUM-1:0] e_rs;
        logic [NUM-1:0] e_ws;
        run  = m_run();
        id   = int'(cpu_bus.accel_id);
        inr  = (id < NUM);
        e_cr = !inr ? 1'b0 : (id == 0 ? run : scr[id]);
        e_cw = !inr ? 1'b1 : (id == 0 ? run : scw[id]);
        e_rd = !inr ? '0 : (id == 0 ? m_arg : srd[id*DW +: DW]);
        e_rs = (run && inr && cpu_bus.accel_read_enable)  ? NUM'(1 << id) : '0;
        e_ws = (run && inr && cpu_bus.accel_write_enable) ? NUM'(1 << id) : '0;
        chk("rnd_ready", ready, !m_busy);
        chk("rnd_cpu_rst", cpu_rst, !run);
        chk("rnd_result", result, m_result);
        chk("rnd_result_valid", result_valid, m_rv);
        chk("rnd_timeout", timeout, m_timeout);
        chk("rnd_can_read", cpu_bus.accel_can_read, e_cr);
        chk("rnd_can_write", cpu_bus.accel_can_write, e_cw);
        chk("rnd_read_data", cpu_bus.accel_read_data, e_rd);
        chk("rnd_read_strobe", srs, e_rs);
        chk("rnd_write_strobe", sws, e_ws);
        chk("rnd_write_data", swd, cpu_bus.accel_write_data);
    endtask

    task automatic model_step();
        bit run;
        bit nrv;
        run = m_run();
        nrv = 1'b0;
        if (rst) begin
            m_busy    = 1'b0;
            m_arg     = '0;
            m_result  = '0;
            m_timeout = 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy    = 1'b1;
                m_t0      = m_cyc;
                m_arg     = arg;
                m_timeout = 1'b0;
                m_idle    = 0;
            end
        end else if (run) begin
            if (cpu_bus.accel_write_enable && cpu_bus.accel_id == 0) begin
                m_result = cpu_bus.accel_write_data;
                nrv      = 1'b1;
                m_busy   = 1'b0;
            end
`ifdef ACCEL_WATCHDOG_EN
            else if (cpu_bus.accel_read_enable || cpu_bus.accel_write_enable) begin
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle == WDC) begin
                    m_result  = '1;
                    nrv       = 1'b1;
                    m_timeout = 1'b1;
                    m_busy    = 1'b0;
                end
            end
`endif
        end
        m_rv = nrv;
        m_cyc++;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: bench did not reach its summary");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        vt[0] = '{4'd1,  1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'hB111, 4'b0000, 4'b0000};
        vt[1] = '{4'd1,  1'b1, 1'b0, 16'h0000, 4'b0010, 4'b0000, 1'b1, 1'b0, 16'hB111, 4'b0010, 4'b0000};
        vt[2] = '{4'd2,  1'b0, 1'b1, 16'h7777, 4'b1111, 4'b0100, 1'b1, 1'b1, 16'hC222, 4'b0000, 4'b0100};
        vt[3] = '{4'd3,  1'b1, 1'b1, 16'h3C3C, 4'b0111, 4'b0111, 1'b0, 1'b0, 16'hD333, 4'b1000, 4'b1000};
        vt[4] = '{4'd9,  1'b1, 1'b1, 16'h9999, 4'b1111, 4'b0000, 1'b0, 1'b1, 16'h0000, 4'b0000, 4'b0000};
        vt[5] = '{4'd15, 1'b0, 1'b1, 16'hFFFF, 4'b1111, 4'b1111, 1'b0, 1'b1, 16'h0000, 4'b0000, 4'b0000};
        vt[6] = '{4'd0,  1'b1, 1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 16'h0042, 4'b0001, 4'b0000};
        vt[7] = '{4'd4,  1'b1, 1'b0, 16'h0000, 4'b1111, 4'b1111, 1'b0, 1'b1, 16'h0000, 4'b0000, 4'b0000};

        rst   = 1'b1;
        start = 1'b0;
        arg   = '0;
        scr   = '0;
        scw   = '0;
        srd   = {16'hD333, 16'hC222, 16'hB111, 16'hA000};
        bus_idle();

        // reset values, and no strobes / closed slot 0 outside RUN
        next();
        next();
        cpu_bus.accel_id           = 4'd1;
        cpu_bus.accel_read_enable  = 1'b1;
        cpu_bus.accel_write_enable = 1'b1;
        settle();
        chk("rst_ready", ready, 1);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_result", result, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_timeout", timeout, 0);
        chk("idle_read_strobe", srs, 0);
        chk("idle_write_strobe", sws, 0);
        next();
        rst = 1'b0;
        cpu_bus.accel_id = 4'd0;
        settle();
        chk("idle_slot0_can_read", cpu_bus.accel_can_read, 0);
        chk("idle_slot0_can_write", cpu_bus.accel_can_write, 0);
        chk("idle_slot0_strobe", srs, 0);
        bus_idle();

        // run with arg 0x0042, then decode table during RUN
        start_run(16'h0042);
        for (int v = 0; v < 8; v++) begin
            next();
            cpu_bus.accel_id           = vt[v].id;
            cpu_bus.accel_read_enable  = vt[v].re;
            cpu_bus.accel_write_enable = vt[v].we;
            cpu_bus.accel_write_data   = vt[v].wd;
            scr = vt[v].scr;
            scw = vt[v].scw;
            settle();
            chk($sformatf("vec%0d_can_read", v), cpu_bus.accel_can_read, vt[v].cr);
            chk($sformatf("vec%0d_can_write", v), cpu_bus.accel_can_write, vt[v].cw);
            chk($sformatf("vec%0d_read_data", v), cpu_bus.accel_read_data, vt[v].rd);
            chk($sformatf("vec%0d_read_strobe", v), srs, vt[v].rs);
            chk($sformatf("vec%0d_write_strobe", v), sws, vt[v].ws);
            chk($sformatf("vec%0d_write_data", v), swd, vt[v].wd);
        end
        next();
        bus_idle();
        settle();
        chk("after_table_still_run", ready, 0);

        // start during RUN is ignored
        next();
        start = 1'b1;
        arg   = 16'hBEEF;
        next();
        start = 1'b0;
        settle();
        chk("start_in_run_ready", ready, 0);
        chk("start_in_run_cpu_rst", cpu_rst, 0);
        cpu_bus.accel_id = 4'd0;
        settle();
        chk("start_in_run_arg_kept", cpu_bus.accel_read_data, 16'h0042);

        // slot-0 write ends the run
        next();
        cpu_bus.accel_id           = 4'd0;
        cpu_bus.accel_write_enable = 1'b1;
        cpu_bus.accel_write_data   = 16'h1234;
        next();
        bus_idle();
        settle();
        chk("done_result", result, 16'h1234);
        chk("done_result_valid", result_valid, 1);
        chk("done_ready", ready, 1);
        chk("done_cpu_rst", cpu_rst, 1);
        next();
        settle();
        chk("done_valid_pulse_end", result_valid, 0);
        chk("done_result_hold", result, 16'h1234);

        // reset in the middle of a run
        start_run(16'h5555);
        next();
        rst = 1'b1;
        next();
        rst = 1'b0;
        settle();
        chk("midrst_ready", ready, 1);
        chk("midrst_cpu_rst", cpu_rst, 1);
        chk("midrst_result", result, 0);
        chk("midrst_result_valid", result_valid, 0);
        next();
        settle();
        chk("midrst_no_pulse", result_valid, 0);

        // stalled CPU
        start_run(16'h0ABC);
`ifdef ACCEL_WATCHDOG_EN
        for (int k = 0; k < WDC - 1; k++) next();
        settle();
        chk("wd_before_expire_ready", ready, 0);
        next();
        settle();
        chk("wd_result", result, 16'hFFFF);
        chk("wd_result_valid", result_valid, 1);
        chk("wd_timeout", timeout, 1);
        chk("wd_ready", ready, 1);
        next();
        start = 1'b1;
        settle();
        chk("wd_timeout_sticky", timeout, 1);
        next();
        start = 1'b0;
        settle();
        chk("wd_timeout_cleared", timeout, 0);
`else
        for (int k = 0; k < 40; k++) next();
        settle();
        chk("stall_still_run", ready, 0);
        chk("stall_cpu_rst", cpu_rst, 0);
        chk("stall_timeout", timeout, 0);
        chk("stall_no_valid", result_valid, 0);
`endif

        // randomized phase against the reference model; cycle 0 resets both
        m_cyc = 0;
        m_t0 = 0;
        m_busy = 1'b0;
        m_arg = '0;
        m_result = '0;
        m_rv = 1'b0;
        m_timeout = 1'b0;
        m_idle = 0;
        for (int i = 0; i < 2500; i++) begin
            next();
            rst   = (i == 0) ? 1'b1 : ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 3) == 0);
            arg   = DW'($urandom);
            cpu_bus.accel_id           = IDW'($urandom_range(0, 15));
            cpu_bus.accel_read_enable  = ($urandom_range(0, 1) == 1);
            cpu_bus.accel_write_enable = ($urandom_range(0, 2) == 0);
            cpu_bus.accel_write_data   = DW'($urandom);
            scr = NUM'($urandom);
            scw = NUM'($urandom);
            srd = {DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom)};
            settle();
            if (i > 0) model_check();
            model_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
